multi_debounce: RTL and testbench

- Multi-channel successor to the single-button debouncer. Each active-high button input gets its own 2-flop synchroniser, stability counter, debounced level, single-cycle press/release pulses and an optional hold-to-auto-repeat pulse train.
- Sits between the board push-buttons and the game FSM, e.g. one channel per mole button, so the FSM consumes clean one-cycle events instead of edge-detecting levels itself.

---
 rtl/multi_debounce.sv | 178 +++++++++++++++++
 tb/tb_multi_debounce.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/multi_debounce.sv
// multi_debounce
// Multi-channel push-button conditioner. Each channel has its own 2-flop
// synchroniser, a stability counter, a debounced level, one-cycle press and
// release pulses, and a hold-to-auto-repeat FSM that emits a pulse train
// while the button stays pressed.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous, active-low reset (clears every register)
//   button_i       raw asynchronous button pins, 1 = pressed
//   repeat_en_i    global auto-repeat enable, synchronous to clk
//   level_o        debounced button state
//   press_pulse_o  1-cycle pulse when level rises
//   release_pulse_o 1-cycle pulse when level falls
//   repeat_pulse_o 1-cycle auto-repeat pulse while held
//   any_press_o    OR of press pulses, aligned with press_pulse_o
//
// All outputs come straight from flops; there is no combinational path from
// any input to any output.
module multi_debounce #(
    parameter int CHANNELS      = 4,
    parameter int DELAY_COUNTS  = 2500,
    parameter int HOLD_COUNTS   = 25_000_000,
    parameter int REPEAT_COUNTS = 5_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] button_i,
    input  logic                repeat_en_i,
    output logic [CHANNELS-1:0] level_o,
    output logic [CHANNELS-1:0] press_pulse_o,
    output logic [CHANNELS-1:0] release_pulse_o,
    output logic [CHANNELS-1:0] repeat_pulse_o,
    output logic                any_press_o
);

    localparam int CW = $clog2(DELAY_COUNTS + 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DELAY_COUNTS);
    localparam logic [31:0]   HOLD_LAST = 32'(HOLD_COUNTS - 1);
    localparam logic [31:0]   REP_LAST  = 32'(REPEAT_COUNTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_e;

    // Per-channel "level is rising at this edge" flags, gathered for any_press.
    logic [CHANNELS-1:0] rise_vec;
    logic                any_press_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic          sync1_q, sync2_q;
        logic          prev_q, prev_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          level_q, level_d;
        logic          press_q, release_q;
        logic          rpt_q, rpt_d;
        logic          rise, fall;
        rpt_state_e    state_q, state_d;
        logic [31:0]   rcnt_q, rcnt_d;

        // Stability stage: any change of the synchronised pin restarts the
        // count; level only follows prev once prev has been stable for
        // DELAY_COUNTS consecutive cycles.
        always_comb begin
            prev_d  = prev_q;
            cnt_d   = cnt_q;
            level_d = level_q;
            if (sync2_q != prev_q) begin
                prev_d = sync2_q;
                cnt_d  = '0;
            end else begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if ((cnt_q == CNT_MAX) && (level_q != prev_q)) begin
                    level_d = prev_q;
                end
            end
        end

        assign rise = level_d & ~level_q;
        assign fall = ~level_d & level_q;
        assign rise_vec[g] = rise;

        // Repeat FSM. A falling level wins over everything else, including a
        // repeat terminal count landing on the same edge.
        always_comb begin
            state_d = state_q;
            rcnt_d  = rcnt_q;
            rpt_d   = 1'b0;
            if (fall) begin
                state_d = ST_IDLE;
                rcnt_d  = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (rise) begin
                            state_d = ST_HELD;
                            rcnt_d  = '0;
                        end
                    end
                    ST_HELD: begin
                        if (!repeat_en_i) begin
                            rcnt_d = '0;
                        end else if (rcnt_q == HOLD_LAST) begin
                            rpt_d   = 1'b1;
                            state_d = ST_REPEAT;
                            rcnt_d  = '0;
                        end else begin
                            rcnt_d = rcnt_q + 32'd1;
                        end
                    end
                    ST_REPEAT: begin
                        if (!repeat_en_i) begin
                            state_d = ST_HELD;
                            rcnt_d  = '0;
                        end else if (rcnt_q == REP_LAST) begin
                            rpt_d  = 1'b1;
                            rcnt_d = '0;
                        end else begin
                            rcnt_d = rcnt_q + 32'd1;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        rcnt_d  = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q   <= 1'b0;
                sync2_q   <= 1'b0;
                prev_q    <= 1'b0;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                rpt_q     <= 1'b0;
                state_q   <= ST_IDLE;
                rcnt_q    <= '0;
            end else begin
                sync1_q   <= button_i[g];
                sync2_q   <= sync1_q;
                prev_q    <= prev_d;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                // Pulses are registered alongside level so they are high in
                // the first cycle the new level is visible.
                press_q   <= rise;
                release_q <= fall;
                rpt_q     <= rpt_d;
                state_q   <= state_d;
                rcnt_q    <= rcnt_d;
            end
        end

        assign level_o[g]         = level_q;
        assign press_pulse_o[g]   = press_q;
        assign release_pulse_o[g] = release_q;
        assign repeat_pulse_o[g]  = rpt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_press_q <= 1'b0;
        end else begin
            any_press_q <= |rise_vec;
        end
    end

    assign any_press_o = any_press_q;

endmodule

// File: tb/tb_multi_debounce.sv
// Directed bench for multi_debounce with CHANNELS=4, DELAY_COUNTS=4,
// HOLD_COUNTS=20, REPEAT_COUNTS=8. Inputs change 1 time unit after a rising
// edge; outputs are sampled at the same point, so "after edge k" values are
// what each check sees.
module tb_multi_debounce;
  localparam int CH = 4;
  localparam int DC = 4;
  localparam int HC = 20;
  localparam int RC = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] button = '0;
  logic          repeat_en = 1'b0;
  logic [CH-1:0] level, press, rel, rpt;
  logic          any;

  multi_debounce #(
    .CHANNELS(CH), .DELAY_COUNTS(DC), .HOLD_COUNTS(HC), .REPEAT_COUNTS(RC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .button_i(button), .repeat_en_i(repeat_en),
    .level_o(level), .press_pulse_o(press), .release_pulse_o(rel),
    .repeat_pulse_o(rpt), .any_press_o(any)
  );

  // clock
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [CH-1:0] button;
    logic [CH-1:0] level;
    logic [CH-1:0] press;
    logic [CH-1:0] rel;
    logic          any;
  } row_t;

  row_t tbl[22];
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // table for the clean press / clean release on channel 0
    for (int k = 0; k < 22; k++) begin
      tbl[k].button = (k < 12) ? 4'b0001 : 4'b0000;
      tbl[k].level  = (k >= 7 && k < 19) ? 4'b0001 : 4'b0000;
      tbl[k].press  = (k == 7) ? 4'b0001 : 4'b0000;
      tbl[k].rel    = (k == 19) ? 4'b0001 : 4'b0000;
      tbl[k].any    = (k == 7);
    end

    // reset
    idle(2);
    check("rst_level", 32'(level), 32'd0);
    check("rst_press", 32'(press), 32'd0);
    check("rst_repeat", 32'(rpt), 32'd0);
    check("rst_any", 32'(any), 32'd0);
    rst_n = 1'b1;
    idle(3);

    // 1. clean press then release on channel 0
    for (int k = 0; k < 22; k++) begin
      button = tbl[k].button;
      step();
      check($sformatf("t1_level_k%0d", k), 32'(level), 32'(tbl[k].level));
      check($sformatf("t1_press_k%0d", k), 32'(press), 32'(tbl[k].press));
      check($sformatf("t1_rel_k%0d", k), 32'(rel), 32'(tbl[k].rel));
      check($sformatf("t1_any_k%0d", k), 32'(any), 32'(tbl[k].any));
    end
    idle(5);

    // 2. bounce on channel 1: toggles every 3 cycles, last toggle leaves it high
    begin
      int presses = 0;
      for (int t = 0; t < 11; t++) begin
        button[1] = ~button[1];
        for (int c = 0; c < 3; c++) begin
          step();
          check("t2_bounce_level", 32'(level), 32'd0);
          check("t2_bounce_press", 32'(press), 32'd0);
        end
      end
      // the last toggle was applied before edge 0 of the loop above's final pass
      // so 3 edges have passed; level rises on relative edge 7
      for (int k = 3; k < 12; k++) begin
        step();
        if (press[1]) presses++;
        check($sformatf("t2_level_k%0d", k), 32'(level), (k >= 7) ? 32'h2 : 32'h0);
        check($sformatf("t2_press_k%0d", k), 32'(press), (k == 7) ? 32'h2 : 32'h0);
      end
      check("t2_press_count", 32'(presses), 32'd1);
    end
    button[1] = 1'b0;
    idle(15);

    // 3. 2-cycle glitch on channel 2
    button[2] = 1'b1;
    idle(2);
    button[2] = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step();
      check("t3_level", 32'(level), 32'd0);
      check("t3_press", 32'(press), 32'd0);
      check("t3_rel", 32'(rel), 32'd0);
    end

    // 4. auto-repeat on channel 3; release lands on a repeat terminal count
    repeat_en = 1'b1;
    exp_q = {32'd27, 32'd35, 32'd43, 32'd51};
    for (int k = 0; k < 76; k++) begin
      button[3] = (k < 52);
      step();
      check($sformatf("t4_press_k%0d", k), 32'(press), (k == 7) ? 32'h8 : 32'h0);
      check($sformatf("t4_level_k%0d", k), 32'(level), (k >= 7 && k < 59) ? 32'h8 : 32'h0);
      check($sformatf("t4_rel_k%0d", k), 32'(rel), (k == 59) ? 32'h8 : 32'h0);
      if (rpt != 4'b0000) begin
        if (exp_q.size() == 0) begin
          check($sformatf("t4_unexpected_repeat_k%0d", k), 32'(rpt), 32'd0);
        end else begin
          check("t4_repeat_cycle", 32'(k), exp_q.pop_front());
          check("t4_repeat_bits", 32'(rpt), 32'h8);
        end
      end
    end
    check("t4_repeats_missing", 32'(exp_q.size()), 32'd0);
    repeat_en = 1'b0;
    idle(5);

    // 5. repeat gating on channel 0
    button[0] = 1'b1;
    for (int k = 0; k <= 100; k++) begin
      step();
      check("t5_no_repeat", 32'(rpt), 32'd0);
    end
    check("t5_level_held", 32'(level), 32'd1);
    repeat_en = 1'b1;  // E = 100
    for (int k = 101; k <= 125; k++) begin
      step();
      check($sformatf("t5_repeat_k%0d", k), 32'(rpt), (k == 120) ? 32'h1 : 32'h0);
    end
    repeat_en = 1'b0;
    button[0] = 1'b0;
    idle(15);

    // 6. simultaneous press on channels 0 and 3, then reset mid-hold
    button = 4'b1001;
    for (int k = 0; k <= 10; k++) begin
      step();
      check($sformatf("t6_press_k%0d", k), 32'(press), (k == 7) ? 32'h9 : 32'h0);
      check($sformatf("t6_any_k%0d", k), 32'(any), (k == 7) ? 32'h1 : 32'h0);
      check($sformatf("t6_level_k%0d", k), 32'(level), (k >= 7) ? 32'h9 : 32'h0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_level", 32'(level), 32'd0);
    check("t6_rst_press", 32'(press), 32'd0);
    check("t6_rst_rel", 32'(rel), 32'd0);
    check("t6_rst_repeat", 32'(rpt), 32'd0);
    check("t6_rst_any", 32'(any), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      step();
      check($sformatf("t6r_level_k%0d", k), 32'(level), (k >= 7) ? 32'h9 : 32'h0);
      check($sformatf("t6r_press_k%0d", k), 32'(press), (k == 7) ? 32'h9 : 32'h0);
      check($sformatf("t6r_any_k%0d", k), 32'(any), (k == 7) ? 32'h1 : 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
